// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package instr_mem_loader_pkg;

  localparam int MAX_WORDS_DEF = 64;
  localparam int WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Byte address of the word that follows the given one; 32-bit wrap is intended.
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles accepted bytes big-endian into a 32-bit word; flags the 4th byte.
// Latency: word_vld is combinational with the 4th byte; word_dat is valid the cycle after.
// Backpressure: none internally; the caller only strobes byte_vld on an accepted byte.
module instr_mem_loader_byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam int CW = $clog2(WORD_BYTES);

  logic [CW-1:0] cnt_q;
  logic [31:0]   word_q;

  // Shift each accepted byte in from the right so the first byte ends up in [31:24].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
    end else if (byte_vld) begin
      word_q <= {word_q[23:0], byte_dat};
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // The word completes on the edge that accepts the last byte of the group.
  always_comb begin
    word_vld = byte_vld && (cnt_q == CW'(WORD_BYTES - 1));
    word_dat = word_q;
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory as big-endian words; optional checksum (LOADER_CHECKSUM_EN).
// Latency: 4 accept cycles + 1 write cycle per word at best; done/error pulse one cycle after the last step.
// Backpressure: byte_ready is low outside RECV/CHECK; an idle gap of BYTE_GAP_LIMIT cycles aborts the load.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int MAX_WORDS      = MAX_WORDS_DEF,
  parameter int BYTE_GAP_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int GW = (BYTE_GAP_LIMIT < 2) ? 1 : $clog2(BYTE_GAP_LIMIT + 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q;
  logic [15:0]   remaining_q;
  logic [GW-1:0] gap_q;
  logic          error_q;
  logic          err_evt;
  logic          accept;
  logic          rx_state;
  logic          timeout;
  logic          count_bad;
  logic          word_vld;
  logic [31:0]   word_dat;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    xor_q;
`endif

  // Which states listen to the byte stream; also qualifies the gap counter.
  always_comb begin
`ifdef LOADER_CHECKSUM_EN
    rx_state = (state_q == RECV) || (state_q == CHECK);
`else
    rx_state = (state_q == RECV);
`endif
    byte_ready = rx_state;
    accept     = byte_valid && rx_state;
    timeout    = rx_state && !accept && (gap_q == GW'(BYTE_GAP_LIMIT - 1));
    count_bad  = {16'd0, word_count} > 32'(MAX_WORDS);
  end

  instr_mem_loader_byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == IDLE),
    .byte_vld (accept && (state_q == RECV)),
    .byte_dat (byte_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the error events that abort or reject a load.
  always_comb begin
    state_d = state_q;
    err_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count == 16'd0) state_d = DONE;
          else if (count_bad)      err_evt = 1'b1;
          else                     state_d = RECV;
        end
      end
      RECV: begin
        if (timeout) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else if (word_vld) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (remaining_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (timeout) begin
          err_evt = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          if (byte_data == xor_q) begin
            state_d = DONE;
          end else begin
            err_evt = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/word bookkeeping, idle-gap counter and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      gap_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        addr_q      <= base_addr;
        remaining_q <= word_count;
      end else if (state_q == WRITE) begin
        addr_q      <= next_word_addr(addr_q);
        remaining_q <= remaining_q - 16'd1;
      end
      if (rx_state && !accept) gap_q <= gap_q + 1'b1;
      else                     gap_q <= '0;
      error_q <= err_evt;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every program byte; the checksum byte itself is not folded in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         xor_q <= '0;
    else if (state_q == IDLE && start)  xor_q <= '0;
    else if (accept && state_q == RECV) xor_q <= xor_q ^ byte_data;
  end
`endif

  // Status and write-port outputs decode directly from state and registers.
  always_comb begin
    wr_en   = (state_q == WRITE);
    wr_addr = addr_q;
    wr_data = word_dat;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    error   = error_q;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int MAXW = 64;
  localparam int GAP  = 20;
  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  instr_mem_loader #(.MAX_WORDS(MAXW), .BYTE_GAP_LIMIT(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  logic [31:0] prog [0:1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every wr_en/done/error pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (wr_en || done || error)) begin
      int  k;
      ev_t e;
      k = wr_en ? K_WR : (done ? K_DONE : K_ERR);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: got kind %0d addr 0x%08h, expected no event", k, wr_addr);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        if (k == K_WR) begin
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
          check("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      tests++;
      fails++;
      $display("FAIL byte_ready_timeout: got ready 0 after %0d cycles, expected 1", n);
    end else begin
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gapped);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8]);
      if (gapped) tick();
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy 1 after %0d cycles, expected 0", n);
    end
    tick();
    tick();
  endtask

  // Full load of prog[0..n-1]; with the checksum build the correct XOR byte follows.
  task automatic run_load(input logic [31:0] base, input int n, input bit gapped);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      push_ev(K_WR, base + 32'(4 * i), prog[i]);
      for (int j = 0; j < 4; j++) cs = cs ^ prog[i][31-8*j -: 8];
    end
    push_ev(K_DONE, 32'd0, 32'd0);
    do_start(base, 16'(n));
    for (int i = 0; i < n; i++) send_word(prog[i], gapped);
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == 8'h00) tick();
`endif
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    check({tag, "_wr_addr"},    wr_addr,             32'd0);
    check({tag, "_wr_data"},    wr_data,             32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = 32'd0;
    word_count = 16'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back bytes, two words from address 0.
    prog[0] = 32'h20080005;
    prog[1] = 32'h2009000A;
    run_load(32'h0, 2, 1'b0);

    // Same program with byte_valid dropping every other cycle.
    run_load(32'h0, 2, 1'b1);

    // Zero-length load: done the cycle after start, no writes.
    push_ev(K_DONE, 32'd0, 32'd0);
    do_start(32'h40, 16'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd1);
    tick();
    check("zero_done_clear", {31'd0, done}, 32'd0);
    check("zero_idle", {31'd0, busy}, 32'd0);
    wait_idle();

    // Oversized load: error pulse, never busy.
    push_ev(K_ERR, 32'd0, 32'd0);
    do_start(32'h80, 16'(MAXW + 1));
    check("over_error", {31'd0, error}, 32'd1);
    check("over_busy", {31'd0, busy}, 32'd0);
    tick();
    check("over_error_clear", {31'd0, error}, 32'd0);
    check("over_busy_after", {31'd0, busy}, 32'd0);
    tick();

    // Three bytes then silence: error exactly GAP idle cycles later, no write.
    push_ev(K_ERR, 32'd0, 32'd0);
    do_start(32'h100, 16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (GAP - 1) tick();
    check("gap_still_busy", {31'd0, busy}, 32'd1);
    check("gap_no_error_yet", {31'd0, error}, 32'd0);
    tick();
    check("gap_error", {31'd0, error}, 32'd1);
    check("gap_idle", {31'd0, busy}, 32'd0);
    wait_idle();

    // Reset mid-word: every output drops at once, no resume after release.
    do_start(32'h200, 16'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_reset_idle", {31'd0, busy}, 32'd0);
    check("post_reset_ready", {31'd0, byte_ready}, 32'd0);

    // Address wrap past the top of the 32-bit space.
    prog[0] = 32'hDEADBEEF;
    prog[1] = 32'h01234567;
    run_load(32'hFFFFFFFC, 2, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Explicit checksum byte: 01^02^04^08 = 0F matches, 0E does not.
    push_ev(K_WR, 32'h300, 32'h01020408);
    push_ev(K_DONE, 32'd0, 32'd0);
    do_start(32'h300, 16'd1);
    send_word(32'h01020408, 1'b0);
    send_byte(8'h0F);
    wait_idle();

    push_ev(K_WR, 32'h300, 32'h01020408);
    push_ev(K_ERR, 32'd0, 32'd0);
    do_start(32'h300, 16'd1);
    send_word(32'h01020408, 1'b0);
    send_byte(8'h0E);
    wait_idle();
`endif

    repeat (4) tick();
    check("expected_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64, giving the largest accepted program length in words.
REQ-002 SHALL have parameter BYTE_GAP_LIMIT, default 255, giving the idle cycles allowed between bytes before timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load.
REQ-006 base_addr  input  32  byte address of the first word, sampled on start.
REQ-007 word_count  input  16  number of words to load, sampled on start.
REQ-008 byte_valid / byte_data  input  1 / 8  incoming program byte stream.
REQ-009 byte_ready  output  1  loader accepts byte_data when byte_valid && byte_ready.
REQ-010 wr_en / wr_addr / wr_data  output  1 / 32 / 32  instruction-memory write port.
REQ-011 busy / done / error  output  1 / 1 / 1  status; done and error are one-cycle pulses.

Function
REQ-012 SHALL implement states IDLE, RECV, WRITE, CHECK, DONE.
REQ-013 IDLE: start with 0 < word_count <= MAX_WORDS -> RECV; word_count == 0 -> DONE; word_count > MAX_WORDS -> error pulse, stay IDLE.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 byte_ready SHALL be 1 only in RECV (and CHECK when enabled); it is combinational from state.
REQ-017 Bytes SHALL assemble big-endian: the first accepted byte goes to wr_data[31:24], the fourth to [7:0].
REQ-018 After the 4th byte is accepted: -> WRITE next cycle.
REQ-019 WRITE: wr_en=1 for exactly one cycle, wr_addr = base_addr + 4*index, wr_data = assembled word.
REQ-020 After WRITE: index+1; remaining == 0 -> CHECK (if enabled) else DONE; otherwise -> RECV.
REQ-021 wr_addr arithmetic SHALL be 32-bit modulo; wrap past 0xFFFFFFFC to 0x00000000 is silent.
REQ-022 Minimum latency per word: 4 accept cycles + 1 WRITE cycle.
REQ-023 In RECV/CHECK, a gap counter SHALL count cycles without an accepted byte; on reaching BYTE_GAP_LIMIT: error pulse -> IDLE with no further wr_en, partial word discarded.
REQ-024 DONE: done=1 for one cycle, -> IDLE.
REQ-025 wr_en, done and error SHALL be 0 in all cycles not stated above.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, with byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, and clear all counters.
REQ-027 Reset mid-load SHALL abandon the load; the next load after release needs a new start.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: after the last WRITE go to CHECK, accept one byte, and compare it with the XOR of all program bytes; match -> DONE; mismatch -> error pulse and no done pulse, -> IDLE.
REQ-029 LOADER_CHECKSUM_EN undefined: no CHECK state logic and no XOR register; last WRITE -> DONE.

Structure
REQ-030 Shared package SHALL hold the state enumeration, default MAX_WORDS, and the WORD_BYTES=4 constant.
REQ-031 Sub-module byte_packer (shift register + byte counter emitting word_valid) is natural; the FSM, address and gap counters stay in the top.

Verification
REQ-032 start, base=0x0, count=2, bytes 20 08 00 05 / 20 09 00 0A back-to-back -> wr_en at 0x0 data 0x20080005, at 0x4 data 0x2009000A, then done pulse.
REQ-033 Same load with byte_valid toggled every other cycle -> identical writes; byte_ready low during WRITE cycles.
REQ-034 count=0 -> done next cycle, no wr_en; count=MAX_WORDS+1 -> error, busy stays 0.
REQ-035 3 bytes sent then silence for BYTE_GAP_LIMIT cycles -> error, no wr_en; rst_n pulsed mid-word -> all outputs 0 at once.
REQ-036 base=0xFFFFFFFC, count=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-037 With LOADER_CHECKSUM_EN, one word 01 02 04 08 and checksum 0x0F -> done; checksum 0x0E -> error and no done.
